// File: rtl/redundancy_sync_ctrl.sv
// Lockstep controller for an N-hart redundant cluster: halt quorum, WFI/interrupt resync,
// bounded recovery with hart exclusion. Optional error log enabled by REDUNDANCY_ERR_LOG_EN.
module redundancy_sync_ctrl #(
  parameter int NHARTS      = 3,
  parameter int TIMEOUT_CYC = 1024,
  parameter int RST_CYC     = 4,
  parameter int MAX_RETRY   = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              safe_mode_i,
  input  logic              safe_config_i,
  input  logic [NHARTS-1:0] master_i,
  input  logic [NHARTS-1:0] init_sync_i,
  input  logic [NHARTS-1:0] halt_ack_i,
  input  logic [NHARTS-1:0] hart_wfi_i,
  input  logic [NHARTS-1:0] hart_intc_ack_i,
  input  logic              vote_error_i,
  input  logic [NHARTS-1:0] vote_id_error_i,
  output logic [NHARTS-1:0] intr_halt_o,
  output logic [NHARTS-1:0] intr_sync_o,
  output logic [NHARTS-1:0] core_rst_o,
  output logic [NHARTS-1:0] sel_boot_o,
  output logic              single_bus_o,
  output logic              voter_en_o,
  output logic              cmp_en_o,
  output logic [NHARTS-1:0] active_mask_o,
`ifdef REDUNDANCY_ERR_LOG_EN
  output logic [NHARTS-1:0] err_log_mask_o,
  output logic [7:0]        err_log_cnt_o,
`endif
  output logic              timeout_o,
  output logic              fault_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_WAIT_WFI, S_INTSYNC, S_LOCKSTEP, S_RELEASE, S_RECOVER
  } state_t;

  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam int RCW = $clog2(RST_CYC + 1);

  function automatic logic [3:0] popcnt(input logic [NHARTS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NHARTS; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t            r_state, w_next;
  logic [TCW-1:0]    r_tcnt;
  logic [RCW-1:0]    r_rcnt;
  logic [NHARTS-1:0] r_active, r_fset, r_master;
  logic              r_cfg, r_timeout, r_fault;
  logic [3:0]        r_retry [NHARTS];

  logic [NHARTS-1:0] w_fset, w_excl, w_active_nxt;
  logic [3:0]        w_acnt, w_hcnt, w_quorum, w_acnt_nxt;
  logic              w_onehot, w_go, w_all_wfi, w_all_intc, w_master_ack;
  logic              w_counting, w_tmo, w_rec_done, w_abort, w_voter;

  assign w_acnt       = popcnt(r_active);
  assign w_hcnt       = popcnt(halt_ack_i & r_active);
  assign w_quorum     = r_cfg ? ((w_acnt >> 1) + 4'd1) : w_acnt;
  assign w_onehot     = (master_i != '0) && ((master_i & (master_i - NHARTS'(1))) == '0);
  assign w_go         = safe_mode_i && w_onehot && |(init_sync_i & master_i & r_active) && !r_fault;
  assign w_all_wfi    = &(hart_wfi_i | ~r_active);
  assign w_all_intc   = &(hart_intc_ack_i | ~r_active);
  assign w_master_ack = |(hart_intc_ack_i & r_master);
  assign w_fset       = vote_id_error_i & r_active;
  assign w_counting   = (r_state == S_HALT) || (r_state == S_WAIT_WFI) ||
                        (r_state == S_INTSYNC) || (r_state == S_RELEASE);
  assign w_tmo        = w_counting && (r_tcnt == TCW'(TIMEOUT_CYC - 1));
  assign w_rec_done   = (r_state == S_RECOVER) && (r_rcnt == RCW'(RST_CYC - 1));
  assign w_voter      = r_cfg && (w_acnt >= 4'd3);

  // Harts that have used up their recovery budget drop out when recovery ends
  always_comb begin
    w_excl = '0;
    for (int i = 0; i < NHARTS; i++) w_excl[i] = (r_retry[i] >= 4'(MAX_RETRY));
  end
  assign w_active_nxt = r_active & ~w_excl;
  assign w_acnt_nxt   = popcnt(w_active_nxt);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE:     if (w_go) w_next = S_HALT;
      S_HALT: begin
        if (w_hcnt >= w_quorum) w_next = S_WAIT_WFI;
        else if (w_tmo) begin w_next = S_IDLE; w_abort = 1'b1; end
      end
      S_WAIT_WFI: begin
        if (w_all_wfi) w_next = S_INTSYNC;
        else if (w_tmo) begin w_next = S_IDLE; w_abort = 1'b1; end
      end
      S_INTSYNC: begin
        if (w_all_intc) w_next = S_LOCKSTEP;
        else if (w_tmo) begin w_next = S_IDLE; w_abort = 1'b1; end
      end
      S_LOCKSTEP: begin
        if (vote_error_i) w_next = (w_fset != '0) ? S_RECOVER : S_WAIT_WFI;
        else if (!safe_mode_i && w_all_wfi) w_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (w_master_ack) w_next = S_IDLE;
        else if (w_tmo) begin w_next = S_IDLE; w_abort = 1'b1; end
      end
      S_RECOVER:  if (w_rec_done) w_next = (w_acnt_nxt < 4'd2) ? S_IDLE : S_WAIT_WFI;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tcnt    <= '0;
      r_rcnt    <= '0;
      r_active  <= '1;
      r_fset    <= '0;
      r_master  <= '0;
      r_cfg     <= 1'b0;
      r_timeout <= 1'b0;
      r_fault   <= 1'b0;
      for (int i = 0; i < NHARTS; i++) r_retry[i] <= '0;
    end else begin
      r_tcnt <= (w_next != r_state) ? '0 : (w_counting ? r_tcnt + TCW'(1) : r_tcnt);
      r_rcnt <= ((r_state == S_RECOVER) && (w_next == S_RECOVER)) ? r_rcnt + RCW'(1) : '0;
      // Master and mode are frozen for the whole sync sequence
      if (r_state == S_IDLE && w_next == S_HALT) begin
        r_master  <= master_i;
        r_cfg     <= safe_config_i;
        r_timeout <= 1'b0;
      end
      if (w_abort) r_timeout <= 1'b1;
      if (w_next == S_LOCKSTEP || w_next == S_IDLE) r_fset <= '0;
      if (r_state == S_LOCKSTEP && vote_error_i) begin
        r_fset <= w_fset;
        for (int i = 0; i < NHARTS; i++)
          if (w_fset[i]) r_retry[i] <= sat_inc4(r_retry[i]);
      end
      if (w_rec_done) begin
        r_active <= w_active_nxt;
        if (w_acnt_nxt < 4'd2) r_fault <= 1'b1;
      end
    end
  end

`ifdef REDUNDANCY_ERR_LOG_EN
  logic [NHARTS-1:0] r_log_mask;
  logic [7:0]        r_log_cnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_log_mask <= '0;
      r_log_cnt  <= '0;
    end else if (r_state == S_LOCKSTEP && w_next == S_RECOVER) begin
      r_log_mask <= w_fset;
      r_log_cnt  <= sat_inc8(r_log_cnt);
    end
  end

  assign err_log_mask_o = r_log_mask;
  assign err_log_cnt_o  = r_log_cnt;
`else
  // Default build carries no error log state.
`endif

  // Moore decode: every output is a function of registered state only
  always_comb begin
    intr_halt_o  = '0;
    intr_sync_o  = '0;
    core_rst_o   = '0;
    sel_boot_o   = '0;
    single_bus_o = 1'b0;
    voter_en_o   = 1'b0;
    cmp_en_o     = 1'b0;
    case (r_state)
      S_HALT:     intr_halt_o = r_active & ~r_master;
      S_WAIT_WFI: sel_boot_o  = r_fset;
      S_INTSYNC: begin
        intr_sync_o  = r_active;
        single_bus_o = 1'b1;
        sel_boot_o   = r_fset;
      end
      S_LOCKSTEP: begin
        single_bus_o = 1'b1;
        voter_en_o   = w_voter;
        cmp_en_o     = !w_voter;
      end
      S_RELEASE:  intr_sync_o = r_master;
      S_RECOVER: begin
        core_rst_o = r_fset;
        sel_boot_o = r_fset;
      end
      default: ;
    endcase
  end

  assign active_mask_o = r_active;
  assign timeout_o     = r_timeout;
  assign fault_o       = r_fault;

endmodule

// File: tb/tb_redundancy_sync_ctrl.sv
// Directed bench for redundancy_sync_ctrl: 3-hart TMR, 5-hart DMR timeout, 2-hart fault.
module tb_redundancy_sync_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 3-hart instance
  logic a_rst, a_safe, a_cfg, a_verr;
  logic [2:0] a_mst, a_init, a_hack, a_wfi, a_iack, a_vid;
  logic [2:0] a_ihalt, a_isync, a_crst, a_boot, a_act;
  logic a_sbus, a_ven, a_cen, a_tmo, a_flt;

  // 5-hart instance
  logic b_rst, b_safe, b_cfg, b_verr;
  logic [4:0] b_mst, b_init, b_hack, b_wfi, b_iack, b_vid;
  logic [4:0] b_ihalt, b_isync, b_crst, b_boot, b_act;
  logic b_sbus, b_ven, b_cen, b_tmo, b_flt;

  // 2-hart instance, one recovery allowed
  logic c_rst, c_safe, c_cfg, c_verr;
  logic [1:0] c_mst, c_init, c_hack, c_wfi, c_iack, c_vid;
  logic [1:0] c_ihalt, c_isync, c_crst, c_boot, c_act;
  logic c_sbus, c_ven, c_cen, c_tmo, c_flt;

  redundancy_sync_ctrl #(.NHARTS(3)) u3 (
    .clk_i(clk), .rst_i(a_rst), .safe_mode_i(a_safe), .safe_config_i(a_cfg),
    .master_i(a_mst), .init_sync_i(a_init), .halt_ack_i(a_hack), .hart_wfi_i(a_wfi),
    .hart_intc_ack_i(a_iack), .vote_error_i(a_verr), .vote_id_error_i(a_vid),
    .intr_halt_o(a_ihalt), .intr_sync_o(a_isync), .core_rst_o(a_crst), .sel_boot_o(a_boot),
    .single_bus_o(a_sbus), .voter_en_o(a_ven), .cmp_en_o(a_cen), .active_mask_o(a_act),
    .timeout_o(a_tmo), .fault_o(a_flt));

  redundancy_sync_ctrl #(.NHARTS(5)) u5 (
    .clk_i(clk), .rst_i(b_rst), .safe_mode_i(b_safe), .safe_config_i(b_cfg),
    .master_i(b_mst), .init_sync_i(b_init), .halt_ack_i(b_hack), .hart_wfi_i(b_wfi),
    .hart_intc_ack_i(b_iack), .vote_error_i(b_verr), .vote_id_error_i(b_vid),
    .intr_halt_o(b_ihalt), .intr_sync_o(b_isync), .core_rst_o(b_crst), .sel_boot_o(b_boot),
    .single_bus_o(b_sbus), .voter_en_o(b_ven), .cmp_en_o(b_cen), .active_mask_o(b_act),
    .timeout_o(b_tmo), .fault_o(b_flt));

  redundancy_sync_ctrl #(.NHARTS(2), .MAX_RETRY(1)) u2 (
    .clk_i(clk), .rst_i(c_rst), .safe_mode_i(c_safe), .safe_config_i(c_cfg),
    .master_i(c_mst), .init_sync_i(c_init), .halt_ack_i(c_hack), .hart_wfi_i(c_wfi),
    .hart_intc_ack_i(c_iack), .vote_error_i(c_verr), .vote_id_error_i(c_vid),
    .intr_halt_o(c_ihalt), .intr_sync_o(c_isync), .core_rst_o(c_crst), .sel_boot_o(c_boot),
    .single_bus_o(c_sbus), .voter_en_o(c_ven), .cmp_en_o(c_cen), .active_mask_o(c_act),
    .timeout_o(c_tmo), .fault_o(c_flt));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: error on LOCKSTEP, wait out recovery, then resync to LOCKSTEP
  task automatic a3_error(input logic [2:0] vid);
    a_wfi = 3'b000; a_verr = 1'b1; a_vid = vid; tick;
    a_verr = 1'b0; a_vid = 3'b000;
    repeat (4) tick;
    a_wfi = 3'b111; tick;
    a_iack = 3'b111; tick;
    a_iack = 3'b000;
  endtask

  task automatic test_reset;
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    tick; tick;
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    checks++; if (a_act !== 3'b111) begin errors++; $display("FAIL rst_active got %b exp 111", a_act); end
    checks++; if ({a_ihalt, a_isync, a_crst, a_boot} !== 12'h000) begin errors++; $display("FAIL rst_vec got %h exp 000", {a_ihalt, a_isync, a_crst, a_boot}); end
    checks++; if ({a_sbus, a_ven, a_cen, a_tmo, a_flt} !== 5'b00000) begin errors++; $display("FAIL rst_flags got %b exp 00000", {a_sbus, a_ven, a_cen, a_tmo, a_flt}); end
    checks++; if (b_act !== 5'b11111) begin errors++; $display("FAIL rst_active5 got %b exp 11111", b_act); end
    checks++; if (c_act !== 2'b11) begin errors++; $display("FAIL rst_active2 got %b exp 11", c_act); end
  endtask

  task automatic test_sync_tmr;
    a_safe = 1'b1; a_cfg = 1'b1; a_mst = 3'b001; a_init = 3'b001;
    tick;
    checks++; if (a_ihalt !== 3'b110) begin errors++; $display("FAIL halt_irq got %b exp 110", a_ihalt); end
    a_init = 3'b000; a_hack = 3'b001;
    tick;
    checks++; if (a_ihalt !== 3'b110) begin errors++; $display("FAIL halt_one_ack got %b exp 110", a_ihalt); end
    a_hack = 3'b011;
    tick;
    checks++; if (a_ihalt !== 3'b000) begin errors++; $display("FAIL halt_quorum got %b exp 000", a_ihalt); end
    a_hack = 3'b000; a_wfi = 3'b111;
    tick;
    checks++; if (a_isync !== 3'b111) begin errors++; $display("FAIL intsync_irq got %b exp 111", a_isync); end
    checks++; if (a_sbus !== 1'b1) begin errors++; $display("FAIL intsync_bus got %b exp 1", a_sbus); end
    a_iack = 3'b111;
    tick;
    a_iack = 3'b000;
    checks++; if ({a_ven, a_cen, a_sbus} !== 3'b101) begin errors++; $display("FAIL lockstep_tmr got %b exp 101", {a_ven, a_cen, a_sbus}); end
    checks++; if (a_isync !== 3'b000) begin errors++; $display("FAIL lockstep_irq got %b exp 000", a_isync); end
  endtask

  task automatic test_recover;
    int n;
    a_wfi = 3'b000; a_verr = 1'b1; a_vid = 3'b100;
    tick;
    a_verr = 1'b0; a_vid = 3'b000;
    checks++; if (a_boot !== 3'b100) begin errors++; $display("FAIL rec_boot got %b exp 100", a_boot); end
    n = 0;
    while (a_crst === 3'b100 && n < 20) begin n++; tick; end
    checks++; if (n != 4) begin errors++; $display("FAIL rec_len got %0d exp 4", n); end
    checks++; if ({a_crst, a_boot} !== 6'b000100) begin errors++; $display("FAIL rec_wait got %b exp 000100", {a_crst, a_boot}); end
    a_wfi = 3'b111;
    tick;
    checks++; if ({a_isync, a_boot} !== 6'b111100) begin errors++; $display("FAIL rec_intsync got %b exp 111100", {a_isync, a_boot}); end
    a_iack = 3'b111;
    tick;
    a_iack = 3'b000;
    checks++; if ({a_ven, a_boot} !== 4'b1000) begin errors++; $display("FAIL rec_lockstep got %b exp 1000", {a_ven, a_boot}); end
  endtask

  task automatic test_exclusion;
    a3_error(3'b100);
    checks++; if ({a_act, a_ven} !== 4'b1111) begin errors++; $display("FAIL excl_second got %b exp 1111", {a_act, a_ven}); end
    a3_error(3'b100);
    checks++; if (a_act !== 3'b011) begin errors++; $display("FAIL excl_mask got %b exp 011", a_act); end
    checks++; if ({a_ven, a_cen, a_sbus, a_flt} !== 4'b0110) begin errors++; $display("FAIL excl_downgrade got %b exp 0110", {a_ven, a_cen, a_sbus, a_flt}); end
  endtask

  task automatic test_zero_fault;
    a_wfi = 3'b000; a_verr = 1'b1; a_vid = 3'b100;
    tick;
    a_verr = 1'b0; a_vid = 3'b000;
    checks++; if ({a_crst, a_boot, a_sbus} !== 7'b0000000) begin errors++; $display("FAIL zf_state got %b exp 0000000", {a_crst, a_boot, a_sbus}); end
    a_wfi = 3'b011;
    tick;
    checks++; if (a_isync !== 3'b011) begin errors++; $display("FAIL zf_intsync got %b exp 011", a_isync); end
    a_iack = 3'b011;
    tick;
    a_iack = 3'b000;
    checks++; if ({a_cen, a_act} !== 4'b1011) begin errors++; $display("FAIL zf_lockstep got %b exp 1011", {a_cen, a_act}); end
  endtask

  task automatic test_release;
    a_safe = 1'b0;
    tick;
    checks++; if ({a_isync, a_sbus} !== 4'b0010) begin errors++; $display("FAIL rel_irq got %b exp 0010", {a_isync, a_sbus}); end
    a_iack = 3'b001;
    tick;
    a_iack = 3'b000;
    checks++; if (a_isync !== 3'b000) begin errors++; $display("FAIL rel_idle got %b exp 000", a_isync); end
  endtask

  task automatic test_rst_in_recover;
    a_safe = 1'b1; a_init = 3'b001; a_wfi = 3'b000;
    tick;
    a_init = 3'b000;
    checks++; if (a_ihalt !== 3'b010) begin errors++; $display("FAIL rr_halt got %b exp 010", a_ihalt); end
    a_hack = 3'b011; tick;
    a_hack = 3'b000; a_wfi = 3'b011; tick;
    a_iack = 3'b011; tick;
    a_iack = 3'b000;
    checks++; if (a_cen !== 1'b1) begin errors++; $display("FAIL rr_lockstep got %b exp 1", a_cen); end
    a_verr = 1'b1; a_vid = 3'b010;
    tick;
    a_verr = 1'b0; a_vid = 3'b000;
    checks++; if (a_crst !== 3'b010) begin errors++; $display("FAIL rr_crst got %b exp 010", a_crst); end
    a_rst = 1'b1;
    tick;
    a_rst = 1'b0;
    checks++; if ({a_crst, a_boot, a_act} !== 9'b000000111) begin errors++; $display("FAIL rr_reset got %b exp 000000111", {a_crst, a_boot, a_act}); end
  endtask

  task automatic test_timeout_dmr;
    int n;
    b_safe = 1'b1; b_cfg = 1'b0; b_mst = 5'b00001; b_init = 5'b00001; b_hack = 5'b01111;
    tick;
    b_init = 5'b00000;
    checks++; if (b_ihalt !== 5'b11110) begin errors++; $display("FAIL to_halt got %b exp 11110", b_ihalt); end
    n = 0;
    while (b_tmo !== 1'b1 && n < 2000) begin tick; n++; end
    checks++; if (n != 1024) begin errors++; $display("FAIL to_cycles got %0d exp 1024", n); end
    checks++; if (b_ihalt !== 5'b00000) begin errors++; $display("FAIL to_irq got %b exp 00000", b_ihalt); end
    tick;
    checks++; if ({b_tmo, b_ihalt} !== 6'b100000) begin errors++; $display("FAIL to_sticky got %b exp 100000", {b_tmo, b_ihalt}); end
    b_init = 5'b00001;
    tick;
    b_init = 5'b00000;
    checks++; if ({b_tmo, b_ihalt} !== 6'b011110) begin errors++; $display("FAIL to_clear got %b exp 011110", {b_tmo, b_ihalt}); end
  endtask

  task automatic test_fault_two;
    c_safe = 1'b1; c_cfg = 1'b0; c_mst = 2'b01; c_init = 2'b01;
    tick;
    c_init = 2'b00;
    checks++; if (c_ihalt !== 2'b10) begin errors++; $display("FAIL f2_halt got %b exp 10", c_ihalt); end
    c_hack = 2'b11; tick;
    c_hack = 2'b00; c_wfi = 2'b11; tick;
    c_iack = 2'b11; tick;
    c_iack = 2'b00; c_wfi = 2'b00;
    checks++; if ({c_ven, c_cen} !== 2'b01) begin errors++; $display("FAIL f2_dmr got %b exp 01", {c_ven, c_cen}); end
    c_verr = 1'b1; c_vid = 2'b10;
    tick;
    c_verr = 1'b0; c_vid = 2'b00;
    repeat (4) tick;
    checks++; if ({c_flt, c_act, c_crst} !== 5'b10100) begin errors++; $display("FAIL f2_fault got %b exp 10100", {c_flt, c_act, c_crst}); end
    c_init = 2'b01;
    tick; tick;
    checks++; if (c_ihalt !== 2'b00) begin errors++; $display("FAIL f2_ignore got %b exp 00", c_ihalt); end
    c_rst = 1'b1;
    tick;
    c_rst = 1'b0;
    checks++; if ({c_flt, c_act} !== 3'b011) begin errors++; $display("FAIL f2_reset got %b exp 011", {c_flt, c_act}); end
    tick;
    checks++; if (c_ihalt !== 2'b10) begin errors++; $display("FAIL f2_restart got %b exp 10", c_ihalt); end
  endtask

  initial begin
    {a_rst, a_safe, a_cfg, a_verr} = '0;
    {a_mst, a_init, a_hack, a_wfi, a_iack, a_vid} = '0;
    {b_rst, b_safe, b_cfg, b_verr} = '0;
    {b_mst, b_init, b_hack, b_wfi, b_iack, b_vid} = '0;
    {c_rst, c_safe, c_cfg, c_verr} = '0;
    {c_mst, c_init, c_hack, c_wfi, c_iack, c_vid} = '0;
    test_reset;
    test_sync_tmr;
    test_recover;
    test_exclusion;
    test_zero_fault;
    test_release;
    test_rst_in_recover;
    test_timeout_dmr;
    test_fault_two;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/redundancy_sync_ctrl.md
Name: redundancy_sync_ctrl

Overview:
Parametrised lockstep controller for an N-hart redundant cluster. It generalises the fixed 3-hart TMR/DMR safe controller to any hart count, with a live participation mask, a configurable halt quorum, and handshake timeouts. On a vote error it runs bounded recovery: reset and resync the faulty harts, and permanently exclude a hart that keeps failing. It sits between the per-hart debug/interrupt logic and the bus voter/comparator.

Parameters:
NHARTS, 3, number of harts (2..8)
TIMEOUT_CYC, 1024, max cycles spent in any handshake state before abort (>=2)
RST_CYC, 4, cycles core reset is held during recovery (>=1)
MAX_RETRY, 3, recoveries allowed per hart before exclusion (1..15)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
safe_mode_i  in  1  request lockstep operation
safe_config_i  in  1  1=TMR (majority vote), 0=DMR (compare)
master_i  in  NHARTS  one-hot master hart select
init_sync_i  in  NHARTS  master's request to start sync
halt_ack_i  in  NHARTS  per-hart debug-halt acknowledge
hart_wfi_i  in  NHARTS  per-hart in-WFI
hart_intc_ack_i  in  NHARTS  per-hart sync-interrupt acknowledge
vote_error_i  in  1  voter/comparator mismatch
vote_id_error_i  in  NHARTS  harts blamed for the mismatch
intr_halt_o  out  NHARTS  halt interrupt to active non-master harts
intr_sync_o  out  NHARTS  sync interrupt
core_rst_o  out  NHARTS  active-high core reset
sel_boot_o  out  NHARTS  select recovery boot address
single_bus_o  out  1  single-bus routing enable
voter_en_o  out  1  TMR voter enable
cmp_en_o  out  1  DMR comparator enable
active_mask_o  out  NHARTS  harts still participating
timeout_o  out  1  sticky handshake-abort flag
fault_o  out  1  sticky: fewer than 2 active harts

Behaviour:
- Reset: FSM=IDLE; active_mask_o=all ones; per-hart retry counters=0; timeout counter=0; all other outputs 0.
- Only active harts are used. Required acks are ANDed over active_mask_o; non-active bits are ignored.
- States and transitions:
  - IDLE: go to HALT when safe_mode_i && |(init_sync_i & master_i & active_mask_o) && !fault_o.
  - HALT: intr_halt_o = active_mask_o & ~master_i. Go to WAIT_WFI once the ack count over the active mask reaches the quorum Q. TMR: Q = floor(A/2)+1. DMR: Q = A. A = popcount(active_mask_o).
  - WAIT_WFI: go to INTSYNC when all active harts assert hart_wfi_i.
  - INTSYNC: intr_sync_o = active_mask_o; single_bus_o=1. Go to LOCKSTEP when all active harts ack.
  - LOCKSTEP: single_bus_o=1. voter_en_o = safe_config_i && A>=3. cmp_en_o = !voter_en_o.
    - vote_error_i has priority and goes to RECOVER. The faulty set F = vote_id_error_i & active_mask_o is latched.
    - Otherwise, !safe_mode_i with all active harts in WFI goes to RELEASE.
  - RELEASE: intr_sync_o = master_i. Go to IDLE when the master acks.
  - RECOVER: core_rst_o=F and sel_boot_o=F for RST_CYC cycles. Retry counters of F increment (saturating).
    - Any hart reaching MAX_RETRY is cleared from active_mask_o.
    - If A<2 afterwards: set fault_o and go to IDLE.
    - Otherwise go to WAIT_WFI (resync). sel_boot_o for F stays high until INTSYNC is left.
- Mode downgrade: in TMR, if A drops to 2, voter_en_o=0 and cmp_en_o=1 for the rest of operation.
- Timeout: a counter clears on every state change and increments in HALT, WAIT_WFI, INTSYNC and RELEASE. When it reaches TIMEOUT_CYC: set timeout_o and go to IDLE, with all interrupts deasserted the next cycle.
- timeout_o and fault_o clear only on rst_i. timeout_o additionally clears when entering HALT.
- Outputs are Moore (registered state decode). Each output is valid the cycle after its state is entered.
- An F of zero (error with no blamed hart) goes to WAIT_WFI resync with no reset and no counter change.
- safe_mode_i deasserting in HALT, WAIT_WFI or INTSYNC has no effect; the sequence completes or times out.
- master_i not one-hot, or master inactive: stay in IDLE.
- rst_i mid-operation: every output returns to its reset value on the next edge.

Optional Feature:
REDUNDANCY_ERR_LOG_EN.
- Defined: adds outputs err_log_mask_o [NHARTS] (last nonzero F) and err_log_cnt_o [7:0] (total RECOVER entries, saturating at 255). Both clear on rst_i.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- NHARTS=3, TMR: init_sync_i=001, master_i=001, acks from harts 0 and 1 only. Expect WAIT_WFI after 2 acks. All WFI then all intc acks give LOCKSTEP with voter_en_o=1 and single_bus_o=1.
- In LOCKSTEP, vote_error_i=1 with vote_id_error_i=100. Expect core_rst_o=100 for exactly 4 cycles, sel_boot_o=100 held, then resync to LOCKSTEP.
- Repeat the hart-2 error 3 times. Expect active_mask_o=011, voter_en_o=0, cmp_en_o=1 after resync.
- NHARTS=5, DMR: a hart never acks halt. Expect timeout_o=1 after 1024 cycles in HALT, FSM back in IDLE, intr_halt_o=0.
- NHARTS=2, exclude one hart: fault_o=1. A subsequent init_sync_i is ignored until rst_i.
- Assert rst_i during RECOVER. Next cycle core_rst_o=0 and active_mask_o is all ones.
